// File: rtl/riscv_pipeline_top.sv
// RV32I five-stage in-order pipeline (IF/ID/EX/MEM/WB) with internal memories,
// EX-stage forwarding, a one-cycle load-use stall and branches resolved in EX.

module riscv_mem #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk_i,
    input  logic [31:0] iaddr_i,
    output logic [31:0] idata_o,
    input  logic [31:0] daddr_i,
    input  logic        dwe_i,
    input  logic [31:0] dwdata_i,
    output logic [31:0] drdata_o
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic        unused_addr_bits;

    assign idata_o          = imem[iaddr_i[IAW+1:2]];
    assign drdata_o         = dmem[daddr_i[DAW+1:2]];
    assign unused_addr_bits = ^{iaddr_i[31:IAW+2], iaddr_i[1:0], daddr_i[31:DAW+2], daddr_i[1:0]};

    // NOTE: memory arrays carry no reset; contents survive reset and are preloaded externally.
    always_ff @(posedge clk_i) begin
        if (dwe_i) dmem[daddr_i[DAW+1:2]] <= dwdata_i;
    end
endmodule

module riscv_rf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] regs [0:31];

    // Same-cycle write data is bypassed so ID never reads a stale value.
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra1_i) ? wd_i : regs[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra2_i) ? wd_i : regs[ra2_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (we_i && wa_i != 5'd0) begin
            regs[wa_i] <= wd_i;
        end
    end
endmodule

module riscv_pipeline_top #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clk,
    input logic reset
);
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        a_sel_e      a_sel;
        logic        b_imm;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic [2:0]  funct3;
    } id_ex_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } ex_mem_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        regwrite;
    } mem_wb_t;

    function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0] pc_q;
    if_id_t      if_id_q;
    id_ex_t      id_ex_q, id_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [31:0] if_instr, rf_rd1, rf_rd2, dmem_rdata;
    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_y, ex_target;
    logic        use_rs1, use_rs2, stall, br_cond, ex_taken;

    riscv_mem #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) mem0 (
        .clk_i(clk), .iaddr_i(pc_q), .idata_o(if_instr),
        .daddr_i(ex_mem_q.result), .dwe_i(ex_mem_q.valid && ex_mem_q.memwrite),
        .dwdata_i(ex_mem_q.store_data), .drdata_o(dmem_rdata)
    );

    riscv_rf rf0 (
        .clk_i(clk), .rst_i(reset),
        .ra1_i(if_id_q.instr[19:15]), .ra2_i(if_id_q.instr[24:20]),
        .rd1_o(rf_rd1), .rd2_o(rf_rd2),
        .we_i(mem_wb_q.valid && mem_wb_q.regwrite), .wa_i(mem_wb_q.rd), .wd_i(mem_wb_q.wdata)
    );

    // ID: unrecognised encodings leave valid clear and travel as bubbles.
    always_comb begin
        logic [31:0] ins;
        ins = if_id_q.instr;
        // NOTE: defaults first on every path so the decoder cannot infer latches.
        id_d         = '0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        id_d.pc      = if_id_q.pc;
        id_d.rs1     = ins[19:15];
        id_d.rs2     = ins[24:20];
        id_d.rd      = ins[11:7];
        id_d.funct3  = ins[14:12];
        id_d.rs1_val = rf_rd1;
        id_d.rs2_val = rf_rd2;
        id_d.imm     = {{20{ins[31]}}, ins[31:20]};
        case (ins[6:0])
            7'b0110111: begin
                {id_d.valid, id_d.regwrite, id_d.b_imm} = 3'b111;
                id_d.a_sel = A_ZERO;
                id_d.imm   = {ins[31:12], 12'd0};
            end
            7'b0010111: begin
                {id_d.valid, id_d.regwrite, id_d.b_imm} = 3'b111;
                id_d.a_sel = A_PC;
                id_d.imm   = {ins[31:12], 12'd0};
            end
            7'b1101111: begin
                {id_d.valid, id_d.regwrite, id_d.jump} = 3'b111;
                id_d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: if (ins[14:12] == 3'b000) begin
                {id_d.valid, id_d.regwrite, id_d.jump, id_d.jalr, use_rs1} = 5'b11111;
            end
            7'b1100011: if (ins[14:13] != 2'b01) begin
                {id_d.valid, id_d.branch, use_rs1, use_rs2} = 4'b1111;
                id_d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0000011: if (ins[14:12] == 3'b010) begin
                {id_d.valid, id_d.regwrite, id_d.memread, id_d.b_imm, use_rs1} = 5'b11111;
            end
            7'b0100011: if (ins[14:12] == 3'b010) begin
                {id_d.valid, id_d.memwrite, id_d.b_imm, use_rs1, use_rs2} = 5'b11111;
                id_d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b0010011: begin
                {id_d.valid, id_d.regwrite, id_d.b_imm, use_rs1} = 4'b1111;
                id_d.alu_op = alu_sel(ins[14:12], ins[14:12] == 3'b101 && ins[30]);
            end
            7'b0110011: if (ins[31:25] == 7'b0000000 || ins[31:25] == 7'b0100000) begin
                {id_d.valid, id_d.regwrite, use_rs1, use_rs2} = 4'b1111;
                id_d.alu_op = alu_sel(ins[14:12], ins[30]);
            end
            default: ;
        endcase
        if (!if_id_q.valid) begin
            id_d    = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    assign stall = id_ex_q.valid && id_ex_q.memread && id_ex_q.rd != 5'd0 &&
                   ((use_rs1 && id_ex_q.rd == id_d.rs1) || (use_rs2 && id_ex_q.rd == id_d.rs2));

    // EX: youngest producer wins; x0 is never forwarded.
    always_comb begin
        fwd_a = id_ex_q.rs1_val;
        if (ex_mem_q.regwrite && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1) fwd_a = ex_mem_q.result;
        else if (mem_wb_q.regwrite && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1) fwd_a = mem_wb_q.wdata;
        fwd_b = id_ex_q.rs2_val;
        if (ex_mem_q.regwrite && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2) fwd_b = ex_mem_q.result;
        else if (mem_wb_q.regwrite && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2) fwd_b = mem_wb_q.wdata;

        case (id_ex_q.a_sel)
            A_PC:    op_a = id_ex_q.pc;
            A_ZERO:  op_a = 32'd0;
            default: op_a = fwd_a;
        endcase
        op_b = id_ex_q.b_imm ? id_ex_q.imm : fwd_b;

        case (id_ex_q.alu_op)
            ALU_SUB:  alu_y = op_a - op_b;
            ALU_AND:  alu_y = op_a & op_b;
            ALU_OR:   alu_y = op_a | op_b;
            ALU_XOR:  alu_y = op_a ^ op_b;
            ALU_SLL:  alu_y = op_a << op_b[4:0];
            ALU_SRL:  alu_y = op_a >> op_b[4:0];
            ALU_SRA:  alu_y = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_SLT:  alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_y = {31'd0, op_a < op_b};
            default:  alu_y = op_a + op_b;
        endcase

        case (id_ex_q.funct3)
            3'b000:  br_cond = fwd_a == fwd_b;
            3'b001:  br_cond = fwd_a != fwd_b;
            3'b100:  br_cond = $signed(fwd_a) < $signed(fwd_b);
            3'b101:  br_cond = $signed(fwd_a) >= $signed(fwd_b);
            3'b110:  br_cond = fwd_a < fwd_b;
            3'b111:  br_cond = fwd_a >= fwd_b;
            default: br_cond = 1'b0;
        endcase
        ex_taken  = id_ex_q.valid && (id_ex_q.jump || (id_ex_q.branch && br_cond));
        ex_target = id_ex_q.jalr ? ((fwd_a + id_ex_q.imm) & ~32'd1) : (id_ex_q.pc + id_ex_q.imm);

        ex_mem_d            = '0;
        ex_mem_d.valid      = id_ex_q.valid;
        ex_mem_d.result     = id_ex_q.jump ? id_ex_q.pc + 32'd4 : alu_y;
        ex_mem_d.store_data = fwd_b;
        ex_mem_d.rd         = id_ex_q.rd;
        ex_mem_d.regwrite   = id_ex_q.regwrite;
        ex_mem_d.memread    = id_ex_q.memread;
        ex_mem_d.memwrite   = id_ex_q.memwrite;

        mem_wb_d          = '0;
        mem_wb_d.valid    = ex_mem_q.valid;
        mem_wb_d.wdata    = ex_mem_q.memread ? dmem_rdata : ex_mem_q.result;
        mem_wb_d.rd       = ex_mem_q.rd;
        mem_wb_d.regwrite = ex_mem_q.regwrite;
    end

    // NOTE: non-blocking updates so each stage latches its upstream register's pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= 32'd0;
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            if (ex_taken) begin
                pc_q    <= ex_target;
                if_id_q <= '0;
                id_ex_q <= '0;
            end else if (stall) begin
                id_ex_q <= '0;
            end else begin
                pc_q    <= pc_q + 32'd4;
                if_id_q <= '{valid: 1'b1, pc: pc_q, instr: if_instr};
                id_ex_q <= id_d;
            end
        end
    end
endmodule

// File: tb/tb_riscv_pipeline_top.sv
// Directed programs for riscv_pipeline_top; results probed in the register file and data memory.

module tb_riscv_pipeline_top;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    riscv_pipeline_top dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUI = 7'b0010111;
    localparam logic [6:0] OPC_JLR = 7'b1100111;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_REG};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic load_begin();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            dut.mem0.imem[i] = 32'h0000_0000;
            dut.mem0.dmem[i] = 32'h0000_0000;
        end
    endtask

    task automatic run(input int n);
        @(negedge clk);
        reset = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        load_begin();
        dut.mem0.imem[0] = enc_i(5, 0, 3'b000, 1, OPC_IMM);
        dut.mem0.imem[1] = enc_i(7, 0, 3'b000, 2, OPC_IMM);
        dut.mem0.imem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
        dut.mem0.imem[3] = enc_r(7'h20, 1, 2, 3'b000, 4);
        run(20);
        begin
            int          rn [4] = '{1, 2, 3, 4};
            logic [31:0] ev [4] = '{32'd5, 32'd7, 32'd12, 32'd2};
            for (int k = 0; k < 4; k++) begin
                compared++;
                if (dut.rf0.regs[rn[k]] !== ev[k]) begin
                    mismatched++;
                    $display("FAIL alu_fwd x%0d: got %h expected %h", rn[k], dut.rf0.regs[rn[k]], ev[k]);
                end
            end
        end
        reset = 1'b1;
        #1;
        compared++;
        if (dut.pc_q !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_pc: got %h expected 00000000", dut.pc_q);
        end
        for (int r = 0; r < 32; r++) begin
            compared++;
            if (dut.rf0.regs[r] !== 32'd0) begin
                mismatched++;
                $display("FAIL reset_reg x%0d: got %h expected 00000000", r, dut.rf0.regs[r]);
            end
        end
    endtask

    task automatic test_reset_abort();
        load_begin();
        dut.mem0.imem[0] = enc_i(32'h55, 0, 3'b000, 1, OPC_IMM);
        dut.mem0.imem[1] = enc_s(8, 1, 0);
        run(3);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if (dut.mem0.dmem[2] !== 32'd0) begin
            mismatched++;
            $display("FAIL abort_store: dmem[2] got %h expected 00000000", dut.mem0.dmem[2]);
        end
    endtask

    task automatic test_load_use();
        load_begin();
        dut.mem0.dmem[0] = 32'h0000_002A;
        dut.mem0.imem[0] = enc_i(0, 0, 3'b010, 5, OPC_LD);
        dut.mem0.imem[1] = enc_i(1, 5, 3'b000, 6, OPC_IMM);
        dut.mem0.imem[2] = enc_s(4, 6, 0);
        // Store lands on edge 6 with no stall, edge 7 with exactly one.
        run(6);
        compared++;
        if (dut.mem0.dmem[1] !== 32'd0) begin
            mismatched++;
            $display("FAIL load_use_early: dmem[1] after edge 6 got %h expected 00000000", dut.mem0.dmem[1]);
        end
        @(negedge clk);
        compared++;
        if (dut.mem0.dmem[1] !== 32'h0000_002B) begin
            mismatched++;
            $display("FAIL load_use_store: dmem[1] after edge 7 got %h expected 0000002b", dut.mem0.dmem[1]);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (dut.rf0.regs[5] !== 32'h2A || dut.rf0.regs[6] !== 32'h2B) begin
            mismatched++;
            $display("FAIL load_use_regs: x5 %h x6 %h expected 0000002a 0000002b", dut.rf0.regs[5], dut.rf0.regs[6]);
        end
    endtask

    task automatic test_branch();
        load_begin();
        dut.mem0.imem[0]  = enc_i(1, 0, 3'b000, 1, OPC_IMM);
        dut.mem0.imem[1]  = enc_b(12, 1, 1, 3'b000);
        dut.mem0.imem[2]  = enc_i(9, 0, 3'b000, 2, OPC_IMM);
        dut.mem0.imem[3]  = enc_i(9, 0, 3'b000, 3, OPC_IMM);
        dut.mem0.imem[4]  = enc_i(3, 0, 3'b000, 4, OPC_IMM);
        dut.mem0.imem[5]  = enc_b(8, 1, 1, 3'b001);
        dut.mem0.imem[6]  = enc_i(6, 0, 3'b000, 5, OPC_IMM);
        dut.mem0.imem[7]  = enc_i(32'hFFFF_FFFF, 0, 3'b000, 6, OPC_IMM);
        dut.mem0.imem[8]  = enc_b(8, 6, 1, 3'b110);
        dut.mem0.imem[9]  = enc_i(1, 0, 3'b000, 7, OPC_IMM);
        dut.mem0.imem[10] = enc_i(2, 0, 3'b000, 8, OPC_IMM);
        run(25);
        begin
            int          rn [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
            logic [31:0] ev [8] = '{32'd1, 32'd0, 32'd0, 32'd3, 32'd6, 32'hFFFF_FFFF, 32'd0, 32'd2};
            for (int k = 0; k < 8; k++) begin
                compared++;
                if (dut.rf0.regs[rn[k]] !== ev[k]) begin
                    mismatched++;
                    $display("FAIL branch x%0d: got %h expected %h", rn[k], dut.rf0.regs[rn[k]], ev[k]);
                end
            end
        end
    endtask

    task automatic test_jumps();
        load_begin();
        dut.mem0.imem[4] = enc_j(8, 1);
        dut.mem0.imem[5] = enc_i(1, 2, 3'b000, 2, OPC_IMM);
        dut.mem0.imem[6] = enc_b(12, 0, 5, 3'b001);
        dut.mem0.imem[7] = enc_i(1, 0, 3'b000, 5, OPC_IMM);
        dut.mem0.imem[8] = enc_i(1, 1, 3'b000, 7, OPC_JLR);
        dut.mem0.imem[9] = enc_i(32'h66, 0, 3'b000, 6, OPC_IMM);
        run(40);
        begin
            int          rn [5] = '{1, 2, 5, 6, 7};
            logic [31:0] ev [5] = '{32'h14, 32'd1, 32'd1, 32'h66, 32'h24};
            for (int k = 0; k < 5; k++) begin
                compared++;
                if (dut.rf0.regs[rn[k]] !== ev[k]) begin
                    mismatched++;
                    $display("FAIL jump x%0d: got %h expected %h", rn[k], dut.rf0.regs[rn[k]], ev[k]);
                end
            end
        end
    endtask

    task automatic test_signed_x0();
        load_begin();
        dut.mem0.imem[0] = enc_i(32'hFFFF_FFFF, 0, 3'b000, 1, OPC_IMM);
        dut.mem0.imem[1] = enc_r(7'h00, 0, 1, 3'b010, 2);
        dut.mem0.imem[2] = enc_r(7'h00, 0, 1, 3'b011, 3);
        dut.mem0.imem[3] = enc_i(5, 0, 3'b000, 0, OPC_IMM);
        dut.mem0.imem[4] = enc_r(7'h00, 0, 0, 3'b000, 5);
        dut.mem0.imem[5] = enc_u(20'h12345, 4, OPC_LUI);
        dut.mem0.imem[6] = enc_i(0, 1, 3'b010, 6, OPC_IMM);
        dut.mem0.imem[7] = enc_i(32'hFFFF_FFFF, 0, 3'b011, 8, OPC_IMM);
        run(20);
        begin
            int          rn [7] = '{0, 2, 3, 4, 5, 6, 8};
            logic [31:0] ev [7] = '{32'd0, 32'd1, 32'd0, 32'h1234_5000, 32'd0, 32'd1, 32'd1};
            for (int k = 0; k < 7; k++) begin
                compared++;
                if (dut.rf0.regs[rn[k]] !== ev[k]) begin
                    mismatched++;
                    $display("FAIL signed_x0 x%0d: got %h expected %h", rn[k], dut.rf0.regs[rn[k]], ev[k]);
                end
            end
        end
    endtask

    task automatic test_shift_auipc();
        load_begin();
        dut.mem0.imem[0] = enc_u(20'h80000, 1, OPC_LUI);
        dut.mem0.imem[1] = enc_i(32'h404, 1, 3'b101, 2, OPC_IMM);
        dut.mem0.imem[2] = enc_i(32'h004, 1, 3'b101, 3, OPC_IMM);
        dut.mem0.imem[3] = enc_i(35, 0, 3'b000, 5, OPC_IMM);
        dut.mem0.imem[4] = enc_r(7'h00, 5, 5, 3'b001, 6);
        dut.mem0.imem[5] = enc_r(7'h20, 5, 1, 3'b101, 8);
        dut.mem0.imem[6] = enc_r(7'h00, 3, 2, 3'b100, 9);
        dut.mem0.imem[8] = enc_u(20'h00001, 7, OPC_AUI);
        dut.mem0.imem[9] = enc_i(32'h7FF, 3, 3'b110, 10, OPC_IMM);
        run(25);
        begin
            int          rn [7] = '{2, 3, 6, 8, 9, 7, 10};
            logic [31:0] ev [7] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0118, 32'hF000_0000,
                                    32'hF000_0000, 32'h0000_1020, 32'h0800_07FF};
            for (int k = 0; k < 7; k++) begin
                compared++;
                if (dut.rf0.regs[rn[k]] !== ev[k]) begin
                    mismatched++;
                    $display("FAIL shift_auipc x%0d: got %h expected %h", rn[k], dut.rf0.regs[rn[k]], ev[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_load_use();
        test_branch();
        test_jumps();
        test_signed_x0();
        test_shift_auipc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/riscv_pipeline_top.md
Name: riscv_pipeline_top

Overview:
- Self-contained RV32I 5-stage in-order pipelined processor: IF, ID, EX, MEM, WB.
- Instruction and data memories are internal.
- The only ports are clock and reset.
- Programs and data are preloaded by the bench through hierarchical access:
  - `mem0.imem` and `mem0.dmem`, via `$readmemh`.
  - Results are checked by probing `mem0.dmem` and `rf0.regs`.

Parameters:
- IMEM_DEPTH, 256: number of 32-bit words in `mem0.imem`.
- DMEM_DEPTH, 256: number of 32-bit words in `mem0.dmem`.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Hierarchy, mandatory names:
  - Instance `mem0` holds arrays `reg [31:0] imem[0:IMEM_DEPTH-1]` and `reg [31:0] dmem[0:DMEM_DEPTH-1]`.
  - Instance `rf0` holds `reg [31:0] regs[0:31]`.
- Memories:
  - Word-addressed: index = byte address[log2(DEPTH)+1:2]. Address bits [1:0] are ignored; higher bits wrap.
  - imem is read combinationally in IF.
  - dmem is read combinationally in MEM and written on the clock edge in MEM.
  - Neither memory is cleared by reset.
- Reset effects:
  - PC = 0.
  - All pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) hold bubbles: valid = 0, no regwrite, no memwrite.
  - `rf0.regs[0..31]` = 0.
  - Reset asserted mid-program aborts all in-flight instructions with no further memory or register writes.
- Supported instructions, RV32I:
  - R-type: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU.
  - I-type ALU: ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI.
  - Memory: LW, SW.
  - Branches: BEQ BNE BLT BGE BLTU BGEU.
  - Jumps: JAL, JALR (target LSB cleared).
  - Upper immediates: LUI, AUIPC.
  - Any other encoding, including FENCE/ECALL/EBREAK and 0x00000000, executes as a NOP.
- Arithmetic:
  - 32-bit wrap-around, no overflow traps.
  - Shifts use the low 5 bits of the shift amount.
  - SLT and branches compare signed; SLTU, BLTU and BGEU compare unsigned.
  - Immediates are sign-extended per the RV32I formats.
- Register file:
  - x0 always reads 0; writes to it are discarded.
  - Write in WB. A same-cycle read of the register being written returns the new value (internal bypass).
- Forwarding:
  - EX operands take EX/MEM results first, then MEM/WB, then the register file.
  - Forwarding never applies to x0.
  - SW store data is also forwarded.
- Load-use hazard: an instruction in ID using the rd of an LW in EX stalls 1 cycle. PC and IF/ID hold; a bubble is inserted into ID/EX.
- Control flow:
  - Branches and jumps resolve in EX.
  - When taken, PC = target; the two younger instructions in IF and ID are flushed to bubbles (2-cycle penalty).
  - Not-taken costs nothing (predict not-taken).
  - JAL and JALR write PC+4 to rd.
- Sequencing: PC increments by 4 each unstalled cycle. Running past the end of imem wraps to word 0.
- Throughput and latency: CPI 1 absent hazards. An instruction fetched in cycle n writes back in cycle n+4.

Test Plan:
- Reset and straight-line ALU:
  - imem = ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; SUB x4,x2,x1, with no NOPs between them.
  - After 20 cycles: x3 = 12 and x4 = 2, proving EX/MEM and MEM/WB forwarding.
  - Asserting reset then gives PC = 0 and all regs = 0.
- Load/store with load-use:
  - dmem[0] = 0x0000002A.
  - Program: LW x5,0(x0); ADDI x6,x5,1; SW x6,4(x0).
  - Required: dmem[1] = 0x2B, with exactly one stall cycle.
- Branch flush:
  - Program: ADDI x1,x0,1; BEQ x1,x1,+12; ADDI x2,x0,9; ADDI x3,x0,9; ADDI x4,x0,3.
  - Required: x2 = x3 = 0 and x4 = 3.
- Jumps:
  - JAL x1,+8 at address 0x10 gives x1 = 0x14, and the instruction at 0x14 is skipped.
  - JALR x0,0(x1) returns to 0x14.
- Signed/unsigned and x0 behaviour:
  - Program: ADDI x1,x0,-1; SLT x2,x1,x0; SLTU x3,x1,x0; ADDI x0,x0,5; LUI x4,0x12345.
  - Required: x2 = 1, x3 = 0, x0 = 0, x4 = 0x12345000.
- Shifts and AUIPC:
  - SRAI of 0x80000000 by 4 gives 0xF8000000.
  - SRLI of 0x80000000 by 4 gives 0x08000000.
  - AUIPC x7,1 at 0x20 gives x7 = 0x1020.
